register_file_reader: RTL and testbench
=======================================

# register_file_reader

Read side of the 32×32-bit register bank. The block accepts a two-operand read request (rs, rt) through a valid/ready handshake and samples the flattened outputs of all 32 registers. It returns both operands through a 2-entry buffered response port. It sits between the decode stage and the register bank, opposite the bank's write path (regWrite/decoder enables).

## Interface
- NUM_REGS, 32, number of registers in the bank
- REG_W, 32, register width in bits
- ADDR_W, 5, register address width ($clog2(NUM_REGS))
- DEPTH, 2, response buffer entries (fixed at 2; other values are not supported)
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  read request present
- req_ready  output  1  block can accept a request this cycle
- rs_addr  input  ADDR_W  first operand register number
- rt_addr  input  ADDR_W  second operand register number
- reg_bus  input  NUM_REGS*REG_W  current register outputs; register i is at bits [i*REG_W +: REG_W]
- wr_en  input  1  bank write in progress this cycle (regWrite)
- wr_addr  input  ADDR_W  register being written
- wr_data  input  REG_W  data being written
- rsp_valid  output  1  response at head of buffer
- rsp_ready  input  1  consumer takes the response
- rs_data  output  REG_W  first operand of the head entry
- rt_data  output  REG_W  second operand of the head entry
- rsp_rs_addr, rsp_rt_addr  output  ADDR_W  addresses of the head entry

## Operation
- Request accept: req_valid && req_ready at a rising edge.
- Response accept: rsp_valid && rsp_ready at a rising edge.
- Each buffer entry holds {rs_addr, rt_addr, rs_data, rt_data}. A 2-bit count tracks occupancy: 0 = empty, 1 = one entry, 2 = full.
- Buffer state machine:
  - EMPTY → ONE on a request accept.
  - ONE → FULL on a request accept without a response accept.
  - ONE → EMPTY on a response accept without a request accept.
  - ONE stays ONE when a request and a response are accepted together.
  - FULL → ONE on a response accept. No request can be accepted while FULL.
- Captured data per operand:
  - address 0 → 0, regardless of reg_bus.
  - otherwise → the reg_bus slice for that address (subject to bypass, see Configuration).
- The head entry drives the rsp_* outputs. When the head pops, the second entry becomes the head in the same edge.

## Timing
- req_ready = (count != 2). It depends only on registered state; there is no combinational path from rsp_ready.
- Latency: a request accepted at edge N is visible at rsp_valid/rs_data from edge N onward (one cycle after presentation) when the buffer was empty.
- A full buffer drained by rsp_ready at edge N raises req_ready after edge N.
- Reset (asynchronous, any time, including mid-transaction):
  - count = 0, rsp_valid = 0, req_ready = 1.
  - all data and address outputs = 0.
  - pending entries are discarded.
- While rsp_valid = 1 and rsp_ready = 0, the head addresses are stable; head data changes only through write snooping (see Configuration).

## Configuration
- Macro: REGFILE_READER_BYPASS_EN.
- Defined:
  - Capture: if wr_en && wr_addr == operand address && address != 0 at the accepting edge, the block captures wr_data instead of the reg_bus slice.
  - Snooping: every valid entry whose stored nonzero address equals wr_addr while wr_en = 1 replaces that operand's data with wr_data at that edge.
  - rs and rt are handled independently, so both may update in one cycle.
- Undefined:
  - The block captures reg_bus only. Held entries never change.
  - Read-after-write hazards are the consumer's responsibility.

## Structure
- regfile_pkg holds NUM_REGS, REG_W, ADDR_W and the entry struct typedef (rs_addr, rt_addr, rs_data, rt_data).
- One sub-module, reg_read_mux: a combinational NUM_REGS:1 slice select from reg_bus with the zero-register override. It is instantiated twice (rs, rt).
- The buffer, count state machine and bypass logic live in the top module.

## Test plan
- Reset mid-operation: fill 2 entries, assert reset → rsp_valid = 0, req_ready = 1, rs_data = rt_data = 0 immediately.
- Basic read: reg 5 = 0xDEADBEEF, reg 9 = 0x12345678, request (5, 9) with rsp_ready = 1 → next cycle rsp_valid = 1, rs_data = 0xDEADBEEF, rt_data = 0x12345678.
- Zero register: request (0, 0) with reg_bus slice 0 forced to 0xFFFFFFFF → rs_data = rt_data = 0.
- Backpressure: rsp_ready = 0, issue 3 back-to-back requests → 2 accepted and req_ready = 0. Then raise rsp_ready → responses pop in order and req_ready = 1 after the first pop.
- Simultaneous push/pop: at count = 1, accept a request and a response in the same cycle → count stays 1 and the new entry becomes the head.
- Bypass (macro defined): request (7, 7) in the same cycle as wr_en with wr_addr = 7 and wr_data = 0xA5A5A5A5 → both operands = 0xA5A5A5A5. Then hold the entry and write 0x1 to reg 7 → head data = 0x1. With the macro undefined → the old reg_bus value is returned and the hold is unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizes, buffer-entry record and occupancy states for the register-bank read path.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int DEPTH    = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [REG_W-1:0]  rs_data;
    logic [REG_W-1:0]  rt_data;
  } rd_entry_t;

  // Encodings double as the buffer occupancy count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/reg_read_mux.sv
// Selects one register out of the flattened bank outputs; register 0 always reads as zero.
module reg_read_mux
  import regfile_pkg::*;
(
  input  logic [NUM_REGS*REG_W-1:0] reg_bus,
  input  logic [ADDR_W-1:0]         addr,
  output logic [REG_W-1:0]          data
);

  always_comb begin
    data = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) data = reg_bus[i*REG_W +: REG_W];
    end
  end

endmodule

// File: rtl/register_file_reader.sv
// Two-operand register read with a 2-entry response buffer.
// Define REGFILE_READER_BYPASS_EN to forward in-flight bank writes into captured and held operands.
module register_file_reader
  import regfile_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         rs_addr,
  input  logic [ADDR_W-1:0]         rt_addr,
  input  logic [NUM_REGS*REG_W-1:0] reg_bus,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [REG_W-1:0]          wr_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [REG_W-1:0]          rs_data,
  output logic [REG_W-1:0]          rt_data,
  output logic [ADDR_W-1:0]         rsp_rs_addr,
  output logic [ADDR_W-1:0]         rsp_rt_addr
);

  buf_state_e state_q, state_d;
  rd_entry_t  entry_q [DEPTH];
  rd_entry_t  entry_d [DEPTH];
  rd_entry_t  snoop   [DEPTH];
  rd_entry_t  new_entry;

  logic [REG_W-1:0] rs_mux, rt_mux;
  logic [DEPTH-1:0] held;
  logic             push, pop, wr_idx;

  reg_read_mux u_rs_mux (.reg_bus(reg_bus), .addr(rs_addr), .data(rs_mux));
  reg_read_mux u_rt_mux (.reg_bus(reg_bus), .addr(rt_addr), .data(rt_mux));

  assign req_ready   = (state_q != BUF_FULL);
  assign rsp_valid   = (state_q != BUF_EMPTY);
  assign push        = req_valid && req_ready;
  assign pop         = rsp_valid && rsp_ready;
  assign held        = {state_q == BUF_FULL, state_q != BUF_EMPTY};
  assign rs_data     = entry_q[0].rs_data;
  assign rt_data     = entry_q[0].rt_data;
  assign rsp_rs_addr = entry_q[0].rs_addr;
  assign rsp_rt_addr = entry_q[0].rt_addr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (push) state_d = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      state_d = BUF_FULL;
        else if (!push && pop) state_d = BUF_EMPTY;
      end
      BUF_FULL:  if (pop) state_d = BUF_ONE;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  always_comb begin
    new_entry.rs_addr = rs_addr;
    new_entry.rt_addr = rt_addr;
    new_entry.rs_data = rs_mux;
    new_entry.rt_data = rt_mux;
    for (int i = 0; i < DEPTH; i++) snoop[i] = entry_q[i];
`ifdef REGFILE_READER_BYPASS_EN
    // A write landing this edge wins over the stale bank value, for new and held operands alike.
    if (wr_en && rs_addr != '0 && rs_addr == wr_addr) new_entry.rs_data = wr_data;
    if (wr_en && rt_addr != '0 && rt_addr == wr_addr) new_entry.rt_data = wr_data;
    for (int i = 0; i < DEPTH; i++) begin
      if (held[i] && wr_en && entry_q[i].rs_addr != '0 && entry_q[i].rs_addr == wr_addr)
        snoop[i].rs_data = wr_data;
      if (held[i] && wr_en && entry_q[i].rt_addr != '0 && entry_q[i].rt_addr == wr_addr)
        snoop[i].rt_data = wr_data;
    end
`endif
  end

`ifndef REGFILE_READER_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data, held};
`endif

  // Pop shifts slot 1 forward; a push lands in the first slot left free after that shift.
  always_comb begin
    wr_idx = (state_q == BUF_ONE) && !pop;
    for (int i = 0; i < DEPTH; i++) entry_d[i] = snoop[i];
    if (pop) begin
      entry_d[0] = snoop[1];
      entry_d[1] = '0;
    end
    if (push) entry_d[wr_idx] = new_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

endmodule

// File: tb/tb_register_file_reader.sv
// Directed self-checking bench for register_file_reader: vector table plus multi-cycle sequences.
module tb_register_file_reader;
  import regfile_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_W-1:0]         rs_addr, rt_addr;
  logic [NUM_REGS*REG_W-1:0] reg_bus;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [REG_W-1:0]          wr_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [REG_W-1:0]          rs_data, rt_data;
  logic [ADDR_W-1:0]         rsp_rs_addr, rsp_rt_addr;

  int n_compared = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [REG_W-1:0]  exp_rs;
    logic [REG_W-1:0]  exp_rt;
  } vec_t;

  vec_t vecs [6];

`ifdef REGFILE_READER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  register_file_reader dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .reg_bus(reg_bus),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rs_data(rs_data), .rt_data(rt_data),
    .rsp_rs_addr(rsp_rs_addr), .rsp_rt_addr(rsp_rt_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReg(input int idx, input logic [REG_W-1:0] val);
    reg_bus[idx*REG_W +: REG_W] = val;
  endtask

  task automatic applyStimulus(input logic rv, input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                               input logic rr, input logic we, input logic [ADDR_W-1:0] wa,
                               input logic [REG_W-1:0] wd);
    req_valid = rv;
    rs_addr   = rs;
    rt_addr   = rt;
    rsp_ready = rr;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
  endtask

  task automatic checkOutput(input string name, input logic [REG_W-1:0] actual, input logic [REG_W-1:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  initial begin
    vecs[0] = '{5'd5,  5'd9,  32'hDEADBEEF, 32'h12345678};
    vecs[1] = '{5'd0,  5'd0,  32'h00000000, 32'h00000000};
    vecs[2] = '{5'd31, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF};
    vecs[3] = '{5'd0,  5'd31, 32'h00000000, 32'hCAFEF00D};
    vecs[4] = '{5'd1,  5'd30, 32'h11111111, 32'h30303030};
    vecs[5] = '{5'd9,  5'd9,  32'h12345678, 32'h12345678};

    reg_bus = '0;
    setReg(0,  32'hFFFFFFFF);
    setReg(1,  32'h11111111);
    setReg(5,  32'hDEADBEEF);
    setReg(7,  32'h77777777);
    setReg(9,  32'h12345678);
    setReg(30, 32'h30303030);
    setReg(31, 32'hCAFEF00D);

    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rs_data", rs_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Table: single request into an empty buffer, popped on the following edge.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].rs, vecs[i].rt, 1'b1, 1'b0, '0, '0);
      checkOutput("vec_req_ready", 32'(req_ready), 32'd1);
      tick();
      checkOutput("vec_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("vec_rs_data", rs_data, vecs[i].exp_rs);
      checkOutput("vec_rt_data", rt_data, vecs[i].exp_rt);
      checkOutput("vec_rs_addr", 32'(rsp_rs_addr), 32'(vecs[i].rs));
      checkOutput("vec_rt_addr", 32'(rsp_rt_addr), 32'(vecs[i].rt));
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
      tick();
      checkOutput("vec_drained", 32'(rsp_valid), 32'd0);
    end

    // Backpressure: three requests offered, only two fit.
    applyStimulus(1'b1, 5'd5, 5'd9, 1'b0, 1'b0, '0, '0);
    tick();
    applyStimulus(1'b1, 5'd31, 5'd1, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("bp_full_req_ready", 32'(req_ready), 32'd0);
    applyStimulus(1'b1, 5'd9, 5'd5, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("bp_still_full", 32'(req_ready), 32'd0);
    checkOutput("bp_head_addr", 32'(rsp_rs_addr), 32'd5);
    checkOutput("bp_head_data", rs_data, 32'hDEADBEEF);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    tick();
    checkOutput("bp_pop1_req_ready", 32'(req_ready), 32'd1);
    checkOutput("bp_pop1_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp_pop1_rs_addr", 32'(rsp_rs_addr), 32'd31);
    checkOutput("bp_pop1_rs_data", rs_data, 32'hCAFEF00D);
    checkOutput("bp_pop1_rt_data", rt_data, 32'h11111111);
    tick();
    checkOutput("bp_pop2_empty", 32'(rsp_valid), 32'd0);

    // Simultaneous push and pop with one entry held.
    applyStimulus(1'b1, 5'd5, 5'd9, 1'b0, 1'b0, '0, '0);
    tick();
    applyStimulus(1'b1, 5'd31, 5'd30, 1'b1, 1'b0, '0, '0);
    tick();
    checkOutput("pp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("pp_req_ready", 32'(req_ready), 32'd1);
    checkOutput("pp_head_rs", rs_data, 32'hCAFEF00D);
    checkOutput("pp_head_rt", rt_data, 32'h30303030);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    tick();
    checkOutput("pp_single_entry", 32'(rsp_valid), 32'd0);

    // Capture bypass and snooping of a held entry.
    applyStimulus(1'b1, 5'd7, 5'd7, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5);
    tick();
    checkOutput("byp_rs", rs_data, BYPASS ? 32'hA5A5A5A5 : 32'h77777777);
    checkOutput("byp_rt", rt_data, BYPASS ? 32'hA5A5A5A5 : 32'h77777777);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 5'd7, 32'h00000001);
    tick();
    checkOutput("snoop_rs", rs_data, BYPASS ? 32'h00000001 : 32'h77777777);
    checkOutput("snoop_rt", rt_data, BYPASS ? 32'h00000001 : 32'h77777777);
    checkOutput("snoop_addr_stable", 32'(rsp_rs_addr), 32'd7);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 5'd9, 32'hBBBBBBBB);
    tick();
    checkOutput("snoop_other_reg", rs_data, BYPASS ? 32'h00000001 : 32'h77777777);

    // Fill the buffer then reset asynchronously between edges.
    applyStimulus(1'b1, 5'd5, 5'd9, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("pre_reset_full", 32'(req_ready), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("async_rst_ready", 32'(req_ready), 32'd1);
    checkOutput("async_rst_rs", rs_data, 32'd0);
    checkOutput("async_rst_rt", rt_data, 32'd0);
    checkOutput("async_rst_addr", 32'(rsp_rs_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 5'd30, 5'd1, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("post_rst_rs", rs_data, 32'h30303030);
    checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
